// File: rtl/pfclk_pattern_gen.sv
// Per-channel square-wave TX word generator for the PF clock link, with gated start-up,
// reconfiguration at period boundaries and a one-period missing-pulse marker.
module pfclk_pattern_gen #(
  parameter int DATA_W   = 20,
  parameter int N_CH     = 1,
  parameter int PERIOD_W = 8
) (
  input  logic                     clk_link,
  input  logic                     soft_reset_n,
  input  logic                     tx_ready,
  input  logic [PERIOD_W-1:0]      cfg_period,
  input  logic [N_CH*PERIOD_W-1:0] cfg_phase,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  output logic                     cfg_err,
  input  logic                     marker_req,
  output logic                     marker_ack,
  output logic [N_CH*DATA_W-1:0]   tx_data,
  output logic                     period_strobe,
  output logic                     running
);

  // Wide enough for pos + bit index + phase, all below their maxima.
  localparam int SUM_W = PERIOD_W + $clog2(DATA_W) + 2;
  localparam logic [PERIOD_W-1:0] DEF_PERIOD = PERIOD_W'(10);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_RUN
  } state_e;

  state_e                   state_q, state_d;
  logic [PERIOD_W-1:0]      act_period_q, act_period_d;
  logic [N_CH*PERIOD_W-1:0] act_phase_q, act_phase_d;
  logic [PERIOD_W-1:0]      shd_period_q, shd_period_d;
  logic [N_CH*PERIOD_W-1:0] shd_phase_q, shd_phase_d;
  logic                     pending_q, pending_d;
  logic [PERIOD_W-1:0]      pos_q, pos_d;
  logic                     mpend_q, mpend_d;
  logic [PERIOD_W-1:0]      remain_q, remain_d;
  logic [N_CH*DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                     cfg_err_q, cfg_err_d;
  logic                     marker_ack_q, marker_ack_d;
  logic                     strobe_q, strobe_d;
  logic                     running_q, running_d;

  logic                     cfg_legal;
  logic                     gen;
  logic                     at_bound;
  logic [PERIOD_W-1:0]      use_period;
  logic [N_CH*PERIOD_W-1:0] use_phase;
  logic [PERIOD_W-1:0]      pos_eff;
  logic [PERIOD_W-1:0]      rem_eff;
  logic [SUM_W-1:0]         p_w;
  logic [SUM_W-1:0]         half_w;
  logic [SUM_W-1:0]         rem_w;
  logic [SUM_W-1:0]         ph_w;
  logic [SUM_W-1:0]         bit_sum;
  logic [SUM_W-1:0]         step_w;
  logic [SUM_W-1:0]         pos_nxt;

  always_comb begin
    cfg_legal = (cfg_period[0] == 1'b0) && (cfg_period >= PERIOD_W'(2));
    for (int c = 0; c < N_CH; c++) begin
      if (cfg_phase[c*PERIOD_W +: PERIOD_W] >= cfg_period) begin
        cfg_legal = 1'b0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    act_period_d = act_period_q;
    act_phase_d  = act_phase_q;
    shd_period_d = shd_period_q;
    shd_phase_d  = shd_phase_q;
    pending_d    = pending_q;
    pos_d        = pos_q;
    mpend_d      = mpend_q;
    remain_d     = remain_q;
    tx_data_d    = '0;
    cfg_err_d    = 1'b0;
    marker_ack_d = 1'b0;
    strobe_d     = 1'b0;
    running_d    = 1'b0;
    gen          = 1'b0;
    at_bound     = 1'b0;
    use_period   = act_period_q;
    use_phase    = act_phase_q;
    pos_eff      = pos_q;
    rem_eff      = remain_q;
    p_w          = '0;
    half_w       = '0;
    rem_w        = '0;
    ph_w         = '0;
    bit_sum      = '0;
    step_w       = '0;
    pos_nxt      = '0;

    if (cfg_valid && !pending_q) begin
      if (cfg_legal) begin
        shd_period_d = cfg_period;
        shd_phase_d  = cfg_phase;
        pending_d    = 1'b1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    if (marker_req && !mpend_q && (remain_q == '0)) begin
      mpend_d = 1'b1;
    end

    // ALIGN emits the pos==0 word itself so the first word lands one cycle after it.
    case (state_q)
      ST_IDLE: begin
        if (tx_ready) begin
          state_d = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        state_d = ST_RUN;
        pos_eff = '0;
        gen     = 1'b1;
      end
      ST_RUN: begin
        if (!tx_ready) begin
          state_d  = ST_IDLE;
          mpend_d  = 1'b0;
          remain_d = '0;
          pos_d    = '0;
        end else begin
          gen = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (gen) begin
      at_bound = (pos_eff == '0);
      if (at_bound && pending_q) begin
        use_period   = shd_period_q;
        use_phase    = shd_phase_q;
        act_period_d = shd_period_q;
        act_phase_d  = shd_phase_q;
        pending_d    = 1'b0;
      end
      if (at_bound && mpend_q) begin
        rem_eff      = use_period;
        mpend_d      = 1'b0;
        marker_ack_d = 1'b1;
      end

      p_w    = SUM_W'(use_period);
      half_w = p_w >> 1;
      rem_w  = SUM_W'(rem_eff);
      for (int c = 0; c < N_CH; c++) begin
        ph_w = SUM_W'(use_phase[c*PERIOD_W +: PERIOD_W]);
        for (int i = 0; i < DATA_W; i++) begin
          bit_sum = SUM_W'(pos_eff) + SUM_W'(i) + ph_w;
          tx_data_d[c*DATA_W + i] = ((bit_sum % p_w) < half_w) && (SUM_W'(i) >= rem_w);
        end
      end

      if (rem_w > SUM_W'(DATA_W)) begin
        remain_d = PERIOD_W'(rem_w - SUM_W'(DATA_W));
      end else begin
        remain_d = '0;
      end

      step_w  = SUM_W'(DATA_W) % p_w;
      pos_nxt = SUM_W'(pos_eff) + step_w;
      if (pos_nxt >= p_w) begin
        pos_nxt = pos_nxt - p_w;
      end
      pos_d     = PERIOD_W'(pos_nxt);
      strobe_d  = at_bound;
      running_d = 1'b1;
    end
  end

  always_ff @(posedge clk_link) begin
    if (!soft_reset_n) begin
      state_q      <= ST_IDLE;
      act_period_q <= DEF_PERIOD;
      act_phase_q  <= '0;
      shd_period_q <= DEF_PERIOD;
      shd_phase_q  <= '0;
      pending_q    <= 1'b0;
      pos_q        <= '0;
      mpend_q      <= 1'b0;
      remain_q     <= '0;
      tx_data_q    <= '0;
      cfg_err_q    <= 1'b0;
      marker_ack_q <= 1'b0;
      strobe_q     <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_period_q <= act_period_d;
      act_phase_q  <= act_phase_d;
      shd_period_q <= shd_period_d;
      shd_phase_q  <= shd_phase_d;
      pending_q    <= pending_d;
      pos_q        <= pos_d;
      mpend_q      <= mpend_d;
      remain_q     <= remain_d;
      tx_data_q    <= tx_data_d;
      cfg_err_q    <= cfg_err_d;
      marker_ack_q <= marker_ack_d;
      strobe_q     <= strobe_d;
      running_q    <= running_d;
    end
  end

  assign cfg_ready     = !pending_q;
  assign cfg_err       = cfg_err_q;
  assign marker_ack    = marker_ack_q;
  assign tx_data       = tx_data_q;
  assign period_strobe = strobe_q;
  assign running       = running_q;

endmodule

// File: tb/tb_pfclk_pattern_gen.sv
// Bench for pfclk_pattern_gen: directed vectors, a bit-stream model built on absolute
// line-bit time, and hand-derived word literals that pin the model.
module tb_pfclk_pattern_gen;

  localparam int DW  = 20;
  localparam int NCH = 2;
  localparam int PW  = 8;

  logic                clk_link = 1'b0;
  logic                soft_reset_n;
  logic                tx_ready;
  logic [PW-1:0]       cfg_period;
  logic [NCH*PW-1:0]   cfg_phase;
  logic                cfg_valid;
  logic                cfg_ready;
  logic                cfg_err;
  logic                marker_req;
  logic                marker_ack;
  logic [NCH*DW-1:0]   tx_data;
  logic                period_strobe;
  logic                running;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk_link = ~clk_link;

  pfclk_pattern_gen #(.DATA_W(DW), .N_CH(NCH), .PERIOD_W(PW)) dut (
    .clk_link      (clk_link),
    .soft_reset_n  (soft_reset_n),
    .tx_ready      (tx_ready),
    .cfg_period    (cfg_period),
    .cfg_phase     (cfg_phase),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_err       (cfg_err),
    .marker_req    (marker_req),
    .marker_ack    (marker_ack),
    .tx_data       (tx_data),
    .period_strobe (period_strobe),
    .running       (running)
  );

  // Model: line bit n of a run is high iff (n + phase) mod P < P/2; marker blanks one period.
  bit                model_valid = 1'b0;
  int                m_state;
  int                m_p, s_p;
  int                m_ph[NCH];
  int                s_ph[NCH];
  bit                m_pend, m_mpend;
  int                m_t, m_blank;
  logic [NCH*DW-1:0] e_data;
  bit                e_err, e_ack, e_strobe, e_run;
  bit                gen, bound, xfer, mreq_ok;
  int                abs_bit;

  function automatic bit cfgLegal(input int p, input logic [NCH*PW-1:0] ph);
    if (p < 2 || (p % 2) != 0) return 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (int'(ph[c*PW +: PW]) >= p) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk_link) begin
    if (!soft_reset_n) begin
      model_valid = 1'b1;
      m_state = 0; m_p = 10; s_p = 10;
      for (int c = 0; c < NCH; c++) begin m_ph[c] = 0; s_ph[c] = 0; end
      m_pend = 1'b0; m_mpend = 1'b0; m_t = 0; m_blank = 0;
      e_data = '0; e_err = 1'b0; e_ack = 1'b0; e_strobe = 1'b0; e_run = 1'b0;
    end else begin
      e_data = '0; e_err = 1'b0; e_ack = 1'b0; e_strobe = 1'b0; e_run = 1'b0;
      xfer    = cfg_valid && !m_pend;
      mreq_ok = marker_req && !m_mpend && !(m_t < m_blank);
      gen = 1'b0;
      if (m_state == 1) begin
        m_t = 0; gen = 1'b1; m_state = 2;
      end else if (m_state == 2) begin
        if (tx_ready) gen = 1'b1;
      end else if (tx_ready) begin
        m_state = 1;
      end
      if (gen) begin
        bound = (m_t % m_p) == 0;
        if (bound && m_pend) begin
          m_p = s_p;
          for (int c = 0; c < NCH; c++) m_ph[c] = s_ph[c];
          m_pend = 1'b0; m_t = 0; m_blank = 0;
        end
        if (bound && m_mpend) begin
          m_blank = m_t + m_p; m_mpend = 1'b0; e_ack = 1'b1;
        end
        for (int c = 0; c < NCH; c++) begin
          for (int i = 0; i < DW; i++) begin
            abs_bit = m_t + i;
            e_data[c*DW + i] = (((abs_bit + m_ph[c]) % m_p) < (m_p / 2)) && (abs_bit >= m_blank);
          end
        end
        e_strobe = bound; e_run = 1'b1;
        m_t = m_t + DW;
      end
      if (xfer) begin
        if (cfgLegal(int'(cfg_period), cfg_phase)) begin
          s_p = int'(cfg_period);
          for (int c = 0; c < NCH; c++) s_ph[c] = int'(cfg_phase[c*PW +: PW]);
          m_pend = 1'b1;
        end else begin
          e_err = 1'b1;
        end
      end
      if (mreq_ok) m_mpend = 1'b1;
      if (m_state == 2 && !tx_ready && !gen) begin
        m_state = 0; m_mpend = 1'b0; m_blank = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_link) begin
    if (model_valid) begin
      checkOutput("tx_data",       64'(tx_data),       64'(e_data));
      checkOutput("cfg_ready",     64'(cfg_ready),     64'(!m_pend));
      checkOutput("cfg_err",       64'(cfg_err),       64'(e_err));
      checkOutput("marker_ack",    64'(marker_ack),    64'(e_ack));
      checkOutput("period_strobe", 64'(period_strobe), 64'(e_strobe));
      checkOutput("running",       64'(running),       64'(e_run));
    end
  end

  task automatic applyStimulus(input logic rdy, input logic vld, input logic [PW-1:0] p,
                               input logic [NCH*PW-1:0] ph, input logic mreq);
    tx_ready   = rdy;
    cfg_valid  = vld;
    cfg_period = p;
    cfg_phase  = ph;
    marker_req = mreq;
    @(negedge clk_link);
  endtask

  task automatic hold(input int n);
    cfg_valid  = 1'b0;
    marker_req = 1'b0;
    repeat (n) @(negedge clk_link);
  endtask

  initial begin
    soft_reset_n = 1'b0;
    tx_ready     = 1'b0;
    cfg_valid    = 1'b0;
    cfg_period   = PW'(10);
    cfg_phase    = '0;
    marker_req   = 1'b0;
    repeat (3) @(negedge clk_link);
    checkOutput("lit_reset_data",  64'(tx_data),   64'h0);
    checkOutput("lit_reset_ready", 64'(cfg_ready), 64'h1);
    checkOutput("lit_reset_run",   64'(running),   64'h0);

    // Start-up with default P=10, phase 0
    soft_reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, PW'(10), '0, 1'b0);
    checkOutput("lit_align_run", 64'(running), 64'h0);
    hold(1);
    checkOutput("lit_first_word",   64'(tx_data),       64'h07C1F_07C1F);
    checkOutput("lit_first_run",    64'(running),       64'h1);
    checkOutput("lit_first_strobe", 64'(period_strobe), 64'h1);
    hold(3);

    // Channel 1 phase 5 gives the inverted pattern
    applyStimulus(1'b1, 1'b1, PW'(10), {8'd5, 8'd0}, 1'b0);
    checkOutput("lit_ready_low", 64'(cfg_ready), 64'h0);
    hold(1);
    checkOutput("lit_phase_word", 64'(tx_data),   64'hF83E0_07C1F);
    checkOutput("lit_ready_back", 64'(cfg_ready), 64'h1);
    hold(2);

    // Marker at P=10: first period of the word blanked
    applyStimulus(1'b1, 1'b0, PW'(10), {8'd5, 8'd0}, 1'b1);
    hold(1);
    checkOutput("lit_marker_ack",  64'(marker_ack), 64'h1);
    checkOutput("lit_marker_word", 64'(tx_data),    64'hF8000_07C00);
    hold(1);
    checkOutput("lit_after_marker", 64'(tx_data), 64'hF83E0_07C1F);

    // Illegal configs: odd period, then phase out of range
    applyStimulus(1'b1, 1'b1, PW'(7), {8'd0, 8'd0}, 1'b0);
    checkOutput("lit_err_odd",       64'(cfg_err),   64'h1);
    checkOutput("lit_err_odd_ready", 64'(cfg_ready), 64'h1);
    hold(1);
    applyStimulus(1'b1, 1'b1, PW'(10), {8'd0, 8'd12}, 1'b0);
    checkOutput("lit_err_phase", 64'(cfg_err), 64'h1);
    hold(2);
    checkOutput("lit_cfg_kept", 64'(tx_data), 64'hF83E0_07C1F);

    // P=6: pos walks 0,2,4
    applyStimulus(1'b1, 1'b1, PW'(6), {8'd0, 8'd0}, 1'b0);
    hold(1);
    checkOutput("lit_p6_word0", 64'(tx_data),       64'hC71C7_C71C7);
    checkOutput("lit_p6_strb0", 64'(period_strobe), 64'h1);
    hold(1);
    checkOutput("lit_p6_word2", 64'(tx_data),       64'h71C71_71C71);
    checkOutput("lit_p6_strb2", 64'(period_strobe), 64'h0);
    hold(2);
    checkOutput("lit_p6_strb0b", 64'(period_strobe), 64'h1);

    // Marker at P=6 waits for the next boundary
    applyStimulus(1'b1, 1'b0, PW'(6), {8'd0, 8'd0}, 1'b1);
    hold(2);
    checkOutput("lit_p6_marker", 64'(tx_data), 64'hC71C0_C71C0);

    // Config and marker landing on the same word: new period applies first
    applyStimulus(1'b1, 1'b1, PW'(10), {8'd0, 8'd0}, 1'b1);
    hold(2);
    checkOutput("lit_cfg_marker_word", 64'(tx_data),    64'h07C00_07C00);
    checkOutput("lit_cfg_marker_ack",  64'(marker_ack), 64'h1);
    hold(1);

    // Drop tx_ready with a marker pending, then restart
    applyStimulus(1'b1, 1'b1, PW'(6), {8'd0, 8'd0}, 1'b0);
    hold(1);
    applyStimulus(1'b1, 1'b0, PW'(6), {8'd0, 8'd0}, 1'b1);
    applyStimulus(1'b0, 1'b0, PW'(6), {8'd0, 8'd0}, 1'b0);
    checkOutput("lit_drop_data", 64'(tx_data), 64'h0);
    checkOutput("lit_drop_run",  64'(running), 64'h0);
    hold(3);
    applyStimulus(1'b1, 1'b0, PW'(6), {8'd0, 8'd0}, 1'b0);
    hold(1);
    checkOutput("lit_restart_word", 64'(tx_data),    64'hC71C7_C71C7);
    checkOutput("lit_restart_ack",  64'(marker_ack), 64'h0);
    hold(4);

    // Soft reset mid-run restores P=10
    soft_reset_n = 1'b0;
    applyStimulus(1'b1, 1'b0, PW'(6), {8'd0, 8'd0}, 1'b0);
    checkOutput("lit_sreset_data", 64'(tx_data), 64'h0);
    soft_reset_n = 1'b1;
    hold(2);
    checkOutput("lit_sreset_word", 64'(tx_data), 64'h07C1F_07C1F);

    // Config offered while idle is taken up by ALIGN
    applyStimulus(1'b0, 1'b0, PW'(8), {8'd3, 8'd0}, 1'b0);
    applyStimulus(1'b0, 1'b1, PW'(8), {8'd3, 8'd0}, 1'b0);
    hold(2);
    checkOutput("lit_idle_pending", 64'(cfg_ready), 64'h0);
    applyStimulus(1'b1, 1'b0, PW'(8), {8'd3, 8'd0}, 1'b0);
    hold(1);
    checkOutput("lit_p8_word", 64'(tx_data), 64'h1E1E1_F0F0F);
    hold(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
